taximeter_core: RTL and testbench

- Clocked, parametrised taximeter fare engine. Successor to the combinational fare calculator.
- Accumulates distance units and waiting minutes from single-cycle pulses through a trip state machine, and computes a registered, saturating fare.
- Adds a night tariff and freezes the fare at trip end.
- Sits between the sensor-pulse conditioning logic and the display/BCD driver.

---
 rtl/taximeter_core.sv | 154 +++++++++++++++
 tb/tb_taximeter_core.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/taximeter_core.sv
// Clocked taximeter fare engine: trip FSM, saturating distance/wait counters,
// day/night tariff and a registered, clamped fare that freezes at trip end.
module taximeter_core #(
  parameter int unsigned MIL_W          = 8,
  parameter int unsigned TIME_W         = 7,
  parameter int unsigned COST_W         = 11,
  parameter int unsigned BASE_FARE      = 8,
  parameter int unsigned BASE_MIL       = 3,
  parameter int unsigned BASE_TIME      = 3,
  parameter int unsigned MIL_RATE       = 2,
  parameter int unsigned NIGHT_MIL_RATE = 3,
  parameter int unsigned TIME_RATE      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              night,
  input  logic              mil_pulse,
  input  logic              min_tick,
  output logic [MIL_W-1:0]  mil,
  output logic [TIME_W-1:0] timee,
  output logic [COST_W-1:0] cost,
  output logic              busy,
  output logic              sat
);

  localparam int unsigned MAX_MIL_RATE = (MIL_RATE > NIGHT_MIL_RATE) ? MIL_RATE : NIGHT_MIL_RATE;
  localparam int unsigned MAX_RATE     = (MAX_MIL_RATE > TIME_RATE) ? MAX_MIL_RATE : TIME_RATE;
  localparam int unsigned RATE_W       = $clog2(MAX_RATE + 2);
  localparam int unsigned CNT_W        = (MIL_W > TIME_W) ? MIL_W : TIME_W;
  localparam int unsigned PROD_W       = CNT_W + RATE_W + 2;
  // Wide enough for base fare plus both products without wrapping.
  localparam int unsigned FARE_W       = ((COST_W + 2) > PROD_W) ? (COST_W + 2) : PROD_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic trip_start_c, trip_clear_c, count_en_c, fare_en_c;
  logic night_q;

  logic              mil_max_c, time_max_c;
  logic [MIL_W-1:0]  mil_d;
  logic [TIME_W-1:0] timee_d;
  logic [FARE_W-1:0] mil_extra_c, time_extra_c, mil_rate_c, fare_c;
  logic              fare_ovf_c;
  logic [COST_W-1:0] cost_fare_c, cost_d;
  logic              sat_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start beats clear in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (stop)  state_d = ST_HOLD;
      ST_HOLD: begin
        if (start)      state_d = ST_RUN;
        else if (clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM control decode; stop in RUN masks same-cycle pulses
  always_comb begin
    trip_start_c = 1'b0;
    trip_clear_c = 1'b0;
    count_en_c   = 1'b0;
    fare_en_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: trip_start_c = start;
      ST_RUN: begin
        count_en_c = !stop;
        fare_en_c  = 1'b1;
      end
      ST_HOLD: begin
        trip_start_c = start;
        trip_clear_c = clear && !start;
      end
      default: ;
    endcase
  end

  // Fare from registered counters, clamped to the output width
  always_comb begin
    mil_extra_c  = '0;
    time_extra_c = '0;
    if (FARE_W'(mil) > FARE_W'(BASE_MIL))
      mil_extra_c = FARE_W'(mil) - FARE_W'(BASE_MIL);
    if (FARE_W'(timee) > FARE_W'(BASE_TIME))
      time_extra_c = FARE_W'(timee) - FARE_W'(BASE_TIME);
    mil_rate_c  = night_q ? FARE_W'(NIGHT_MIL_RATE) : FARE_W'(MIL_RATE);
    fare_c      = FARE_W'(BASE_FARE) + mil_rate_c * mil_extra_c
                + FARE_W'(TIME_RATE) * time_extra_c;
    fare_ovf_c  = fare_c > FARE_W'({COST_W{1'b1}});
    cost_fare_c = fare_ovf_c ? {COST_W{1'b1}} : fare_c[COST_W-1:0];
  end

  // Counter, cost and sticky-saturation next values
  always_comb begin
    mil_max_c  = &mil;
    time_max_c = &timee;
    mil_d      = mil;
    timee_d    = timee;
    cost_d     = cost;
    sat_d      = sat;
    if (trip_start_c || trip_clear_c) begin
      mil_d   = '0;
      timee_d = '0;
    end else if (count_en_c) begin
      if (mil_pulse && !mil_max_c) mil_d   = mil + MIL_W'(1);
      if (min_tick && !time_max_c) timee_d = timee + TIME_W'(1);
    end
    if (trip_clear_c)   cost_d = COST_W'(BASE_FARE);
    else if (fare_en_c) cost_d = cost_fare_c;
    if (trip_start_c) begin
      sat_d = 1'b0;
    end else begin
      if (count_en_c && ((mil_pulse && mil_max_c) || (min_tick && time_max_c))) sat_d = 1'b1;
      if (fare_en_c && fare_ovf_c) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mil     <= '0;
      timee   <= '0;
      cost    <= COST_W'(BASE_FARE);
      busy    <= 1'b0;
      sat     <= 1'b0;
      night_q <= 1'b0;
    end else begin
      mil   <= mil_d;
      timee <= timee_d;
      cost  <= cost_d;
      busy  <= (state_d == ST_RUN);
      sat   <= sat_d;
      if (trip_start_c) night_q <= night;
    end
  end

endmodule

// File: tb/tb_taximeter_core.sv
// Scoreboard bench for taximeter_core: a trip-level reference model predicts
// every cycle for an 11-bit and a 9-bit fare instance driven in parallel.
`timescale 1ns/1ps
module tb_taximeter_core;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  typedef struct {
    int mil;
    int timee;
    int cost;
    int busy;
    int sat;
    int cost9;
    int sat9;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start, stop, clear, night, mil_pulse, min_tick;
  logic [7:0]  mil, mil9;
  logic [6:0]  timee, timee9;
  logic [10:0] cost;
  logic [8:0]  cost9;
  logic        busy, busy9, sat, sat9;

  int n_pass = 0;
  int n_total = 0;

  exp_t sb[$];

  int m_st = M_IDLE, m_mil = 0, m_time = 0, m_nl = 0;
  int m_cost = 8, m_sat = 0, m_cost9 = 8, m_sat9 = 0;

  always #5 clk = ~clk;

  taximeter_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .night(night), .mil_pulse(mil_pulse), .min_tick(min_tick),
    .mil(mil), .timee(timee), .cost(cost), .busy(busy), .sat(sat)
  );

  taximeter_core #(.COST_W(9)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .night(night), .mil_pulse(mil_pulse), .min_tick(min_tick),
    .mil(mil9), .timee(timee9), .cost(cost9), .busy(busy9), .sat(sat9)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int fare(input int m, input int t, input int nl);
    int r;
    r = 8;
    if (m > 3) r += (nl != 0 ? 3 : 2) * (m - 3);
    if (t > 3) r += t - 3;
    return r;
  endfunction

  // Advance the reference model by one clock edge for the given inputs
  task automatic model(input bit rs, input bit st, input bit sp, input bit cl,
                       input bit nt, input bit mp, input bit mt);
    int f;
    if (!rs) begin
      m_st = M_IDLE; m_mil = 0; m_time = 0; m_nl = 0;
      m_cost = 8; m_sat = 0; m_cost9 = 8; m_sat9 = 0;
      return;
    end
    f = fare(m_mil, m_time, m_nl);
    if (m_st == M_RUN) begin
      if (f > 2047) begin m_cost = 2047; m_sat = 1; end else m_cost = f;
      if (f > 511)  begin m_cost9 = 511; m_sat9 = 1; end else m_cost9 = f;
    end
    case (m_st)
      M_RUN: begin
        if (sp) m_st = M_HOLD;
        else begin
          if (mp) begin
            if (m_mil == 255) begin m_sat = 1; m_sat9 = 1; end else m_mil++;
          end
          if (mt) begin
            if (m_time == 127) begin m_sat = 1; m_sat9 = 1; end else m_time++;
          end
        end
      end
      default: begin
        if (st) begin
          m_st = M_RUN; m_mil = 0; m_time = 0; m_nl = nt;
          m_sat = 0; m_sat9 = 0;
        end else if (m_st == M_HOLD && cl) begin
          m_st = M_IDLE; m_mil = 0; m_time = 0; m_cost = 8; m_cost9 = 8;
        end
      end
    endcase
  endtask

  // One clock: drive, predict, then compare both instances after the edge
  task automatic step(input bit rs, input bit st, input bit sp, input bit cl,
                      input bit nt, input bit mp, input bit mt);
    exp_t e;
    rst_n = rs; start = st; stop = sp; clear = cl;
    night = nt; mil_pulse = mp; min_tick = mt;
    model(rs, st, sp, cl, nt, mp, mt);
    e.mil = m_mil; e.timee = m_time; e.cost = m_cost; e.busy = (m_st == M_RUN);
    e.sat = m_sat; e.cost9 = m_cost9; e.sat9 = m_sat9;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("mil",    int'(mil),    e.mil);
    check("timee",  int'(timee),  e.timee);
    check("cost",   int'(cost),   e.cost);
    check("busy",   int'(busy),   e.busy);
    check("sat",    int'(sat),    e.sat);
    check("mil9",   int'(mil9),   e.mil);
    check("timee9", int'(timee9), e.timee);
    check("cost9",  int'(cost9),  e.cost9);
    check("busy9",  int'(busy9),  e.busy);
    check("sat9",   int'(sat9),   e.sat9);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    night = 1'b0; mil_pulse = 1'b0; min_tick = 1'b0;

    // Reset, then pulses in IDLE are ignored
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 1);
    check("rst_cost", int'(cost), 8);
    check("rst_busy", int'(busy), 0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1);
    check("idle_mil", int'(mil), 0);
    check("idle_timee", int'(timee), 0);

    // Day trip: 5 units, 6 minutes
    step(1, 1, 0, 0, 0, 0, 0);
    check("run_busy", int'(busy), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    check("day_lag_cost", int'(cost), 14);
    idle(1);
    check("day_cost", int'(cost), 15);
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 1);
    check("hold_cost", int'(cost), 15);
    check("hold_mil", int'(mil), 5);
    check("hold_timee", int'(timee), 6);
    check("hold_busy", int'(busy), 0);

    // Night trip from HOLD, boundary at the free allowance
    step(1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 1);
    idle(1);
    check("night_base", int'(cost), 8);
    step(1, 0, 0, 0, 0, 1, 0);
    idle(1);
    check("night_cost", int'(cost), 11);

    // stop drops a same-cycle pulse; start beats clear in HOLD
    step(1, 0, 1, 0, 0, 1, 1);
    check("stop_drop_mil", int'(mil), 4);
    step(1, 1, 0, 1, 0, 0, 0);
    check("sc_busy", int'(busy), 1);
    check("sc_mil", int'(mil), 0);

    // Distance counter saturation and fare clamp on the narrow instance
    for (int i = 0; i < 256; i++) step(1, 0, 0, 0, 0, 1, 0);
    idle(1);
    check("sat_mil", int'(mil), 255);
    check("sat_cost11", int'(cost), 512);
    check("sat_cost9", int'(cost9), 511);
    check("sat_flag9", int'(sat9), 1);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    check("clear_cost", int'(cost), 8);
    check("clear_sat_kept", int'(sat9), 1);
    step(1, 1, 0, 0, 0, 0, 0);
    check("restart_sat", int'(sat), 0);
    check("restart_sat9", int'(sat9), 0);

    // Reset mid-trip
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 1, 0);
    check("pre_rst_mil", int'(mil), 7);
    step(0, 0, 0, 0, 0, 1, 1);
    check("mid_rst_mil", int'(mil), 0);
    check("mid_rst_cost", int'(cost), 8);
    check("mid_rst_busy", int'(busy), 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
